// File: rtl/music_player.sv
// ---------------------------------------------------------------------------
// music_player
//   Streams samples from an external sample ROM (one-cycle registered read)
//   to a codec at a fixed sample pace. A valid/ack handshake handles slow
//   consumers.
//
// Parameters
//   MEM_DEPTH : number of ROM words; the last address is MEM_DEPTH-1
//   DIV       : Clk cycles per sample period (DIV >= 4)
//
// Ports
//   Clk           : clock, rising edge
//   Reset_n       : synchronous active-low reset
//   play_req      : one-cycle start pulse (ignored while playing)
//   stop_req      : one-cycle abort pulse (beats play_req)
//   loop_en       : wrap to address 0 at end of memory instead of stopping
//   Add           : ROM address
//   music_content : ROM read data, valid one cycle after Add
//   vol           : (MUSIC_VOLUME_EN only) attenuation, sample >> vol
//   sample_out    : current sample to the codec
//   sample_valid  : sample_out holds an unconsumed sample
//   sample_ack    : codec consumed sample_out
//   playing       : high whenever the FSM is not IDLE
//   done          : one-cycle pulse at the natural end of playback
//
// Build option
//   MUSIC_VOLUME_EN : adds the vol input and the logical-shift attenuator
// ---------------------------------------------------------------------------
module music_player #(
  parameter int unsigned MEM_DEPTH = 80550,
  parameter int unsigned DIV       = 1134
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        play_req,
  input  logic        stop_req,
  input  logic        loop_en,
  output logic [16:0] Add,
  input  logic [16:0] music_content,
`ifdef MUSIC_VOLUME_EN
  input  logic [2:0]  vol,
`endif
  output logic [16:0] sample_out,
  output logic        sample_valid,
  input  logic        sample_ack,
  output logic        playing,
  output logic        done
);

  localparam int          PW       = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] RELOAD = PW'(DIV - 1);
  localparam logic [16:0] LAST_ADD = 17'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    LATCH,
    HOLD
  } state_t;

  state_t        state;
  logic [PW-1:0] pace;
  logic [16:0]   scaled;
  logic          acked;

`ifdef MUSIC_VOLUME_EN
  always_comb begin
    scaled = music_content >> vol;
  end
`else
  always_comb begin
    scaled = music_content;
  end
`endif

  // A sample counts as consumed if acked this cycle or already consumed.
  always_comb begin
    acked = sample_ack || !sample_valid;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state        <= IDLE;
      Add          <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
      pace         <= '0;
      playing      <= 1'b0;
    end else begin
      done <= 1'b0;

      // Pace counter runs through READ/LATCH/HOLD so the period is exactly
      // DIV cycles from one READ entry to the next; reloads below override.
      if (state != IDLE && pace != '0) begin
        pace <= pace - 1'b1;
      end

      if (sample_valid && sample_ack) begin
        sample_valid <= 1'b0;
      end

      if (stop_req) begin
        // Stop wins over play; in IDLE it is a no-op and blocks any start.
        if (state != IDLE) begin
          state        <= IDLE;
          playing      <= 1'b0;
          sample_valid <= 1'b0;
          Add          <= '0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (play_req) begin
              Add     <= '0;
              pace    <= RELOAD;
              state   <= READ;
              playing <= 1'b1;
            end
          end

          // Covers the ROM read latency; Add is held.
          READ: begin
            state <= LATCH;
          end

          LATCH: begin
            sample_out   <= scaled;
            sample_valid <= 1'b1;
            state        <= HOLD;
          end

          HOLD: begin
            if (acked && pace == '0) begin
              sample_valid <= 1'b0;
              if (Add < LAST_ADD) begin
                Add   <= Add + 17'd1;
                pace  <= RELOAD;
                state <= READ;
              end else if (loop_en) begin
                Add   <= '0;
                pace  <= RELOAD;
                state <= READ;
              end else begin
                done    <= 1'b1;
                Add     <= '0;
                state   <= IDLE;
                playing <= 1'b0;
              end
            end
          end

          default: begin
            state   <= IDLE;
            playing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_music_player.sv
// ---------------------------------------------------------------------------
// tb_music_player
//   Directed bench for music_player with MEM_DEPTH=4, DIV=4 and a registered
//   4-word ROM model. Expected samples come from the bench's own ROM table.
//   Define MUSIC_VOLUME_EN to also exercise the attenuator (vol=2).
// ---------------------------------------------------------------------------
module tb_music_player;

  logic        Clk;
  logic        Reset_n;
  logic        play_req;
  logic        stop_req;
  logic        loop_en;
  logic [16:0] Add;
  logic [16:0] music_content;
  logic [16:0] sample_out;
  logic        sample_valid;
  logic        sample_ack;
  logic        playing;
  logic        done;
`ifdef MUSIC_VOLUME_EN
  logic [2:0]  vol;
`endif

  logic [16:0] rom [0:3];

  int checks;
  int errors;
  int done_cnt;

  music_player #(
    .MEM_DEPTH(4),
    .DIV(4)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .play_req(play_req),
    .stop_req(stop_req),
    .loop_en(loop_en),
    .Add(Add),
    .music_content(music_content),
`ifdef MUSIC_VOLUME_EN
    .vol(vol),
`endif
    .sample_out(sample_out),
    .sample_valid(sample_valid),
    .sample_ack(sample_ack),
    .playing(playing),
    .done(done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Registered ROM: data for Add appears one cycle later.
  always @(posedge Clk) begin
    music_content <= rom[Add[1:0]];
  end

  always @(negedge Clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  function automatic logic [16:0] expv(input int idx);
    logic [16:0] w;
    w = rom[idx % 4];
`ifdef MUSIC_VOLUME_EN
    w = w >> vol;
`endif
    return w;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps at least once, then until sample_valid is seen (bounded).
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (sample_valid !== 1'b1 && n < 40);
    checks++;
    assert (sample_valid === 1'b1) else begin
      errors++;
      $error("FAIL %s: timeout waiting for sample_valid observed=%0b expected=1", tag, sample_valid);
    end
  endtask

  task automatic pulse_play();
    play_req = 1'b1;
    step();
    play_req = 1'b0;
  endtask

  initial begin
    int n;
    int d0;
    logic stable;

    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    rom[0] = 17'h00011;
    rom[1] = 17'h00022;
    rom[2] = 17'h00033;
    rom[3] = 17'h00044;
    Reset_n    = 1'b0;
    play_req   = 1'b0;
    stop_req   = 1'b0;
    loop_en    = 1'b0;
    sample_ack = 1'b0;
`ifdef MUSIC_VOLUME_EN
    vol = 3'd0;
`endif

    // Reset state
    step();
    step();
    check("rst_add", 32'(Add), 32'h0);
    check("rst_sample", 32'(sample_out), 32'h0);
    check("rst_valid", 32'(sample_valid), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_playing", 32'(playing), 32'h0);
    Reset_n = 1'b1;
    step();
    check("idle_playing", 32'(playing), 32'h0);

    // Scenario 1: ack high, no loop
    sample_ack = 1'b1;
    loop_en    = 1'b0;
    d0 = done_cnt;
    pulse_play();
    check("s1_playing", 32'(playing), 32'h1);
    for (int i = 0; i < 4; i++) begin
      wait_valid("s1_wait", n);
      check("s1_interval", 32'(n), (i == 0) ? 32'd2 : 32'd4);
      check("s1_sample", 32'(sample_out), 32'(expv(i)));
      check("s1_add", 32'(Add), 32'(i));
    end
    step();
    check("s1_done_early", 32'(done), 32'h0);
    check("s1_still_playing", 32'(playing), 32'h1);
    step();
    check("s1_done", 32'(done), 32'h1);
    check("s1_end_playing", 32'(playing), 32'h0);
    check("s1_end_add", 32'(Add), 32'h0);
    step();
    check("s1_done_once", 32'(done), 32'h0);
    check("s1_done_cnt", 32'(done_cnt), 32'(d0 + 1));

    // Scenario 2: loop enabled
    loop_en = 1'b1;
    d0 = done_cnt;
    pulse_play();
    for (int i = 0; i < 5; i++) begin
      wait_valid("s2_wait", n);
      check("s2_interval", 32'(n), (i == 0) ? 32'd2 : 32'd4);
      check("s2_sample", 32'(sample_out), 32'(expv(i)));
    end
    check("s2_wrap_add", 32'(Add), 32'h0);
    check("s2_playing", 32'(playing), 32'h1);
    check("s2_no_done", 32'(done_cnt), 32'(d0));
    loop_en  = 1'b0;
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    check("s2_stop_playing", 32'(playing), 32'h0);
    check("s2_stop_add", 32'(Add), 32'h0);

    // Scenario 3: slow codec, ack 10 cycles after valid
    sample_ack = 1'b0;
    d0 = done_cnt;
    pulse_play();
    for (int i = 0; i < 4; i++) begin
      wait_valid("s3_wait", n);
      check("s3_latency", 32'(n), 32'd2);
      check("s3_sample", 32'(sample_out), 32'(expv(i)));
      stable = 1'b1;
      repeat (10) begin
        step();
        if (sample_valid !== 1'b1 || sample_out !== expv(i)) stable = 1'b0;
      end
      check("s3_stable", 32'(stable), 32'h1);
      sample_ack = 1'b1;
      step();
      sample_ack = 1'b0;
      check("s3_valid_clr", 32'(sample_valid), 32'h0);
      check("s3_done", 32'(done), (i == 3) ? 32'h1 : 32'h0);
      check("s3_playing", 32'(playing), (i == 3) ? 32'h0 : 32'h1);
    end
    step();
    check("s3_done_cnt", 32'(done_cnt), 32'(d0 + 1));

    // Scenario 4: stop during HOLD of second sample, then play+stop in IDLE
    sample_ack = 1'b1;
    d0 = done_cnt;
    pulse_play();
    wait_valid("s4_wait0", n);
    wait_valid("s4_wait1", n);
    check("s4_sample", 32'(sample_out), 32'(expv(1)));
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    check("s4_playing", 32'(playing), 32'h0);
    check("s4_valid", 32'(sample_valid), 32'h0);
    check("s4_add", 32'(Add), 32'h0);
    check("s4_done", 32'(done), 32'h0);
    play_req = 1'b1;
    stop_req = 1'b1;
    step();
    play_req = 1'b0;
    stop_req = 1'b0;
    check("s4_both_playing", 32'(playing), 32'h0);
    step();
    check("s4_both_playing2", 32'(playing), 32'h0);
    check("s4_both_valid", 32'(sample_valid), 32'h0);
    check("s4_no_done", 32'(done_cnt), 32'(d0));

    // Scenario 5: reset asserted while in LATCH
    d0 = done_cnt;
    pulse_play();
    step();
    check("s5_pre_playing", 32'(playing), 32'h1);
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    check("s5_add", 32'(Add), 32'h0);
    check("s5_sample", 32'(sample_out), 32'h0);
    check("s5_valid", 32'(sample_valid), 32'h0);
    check("s5_done", 32'(done), 32'h0);
    check("s5_playing", 32'(playing), 32'h0);
    step();
    step();
    check("s5_idle", 32'(playing), 32'h0);
    check("s5_no_done", 32'(done_cnt), 32'(d0));

`ifdef MUSIC_VOLUME_EN
    // Scenario 6: attenuation by 2
    vol = 3'd2;
    pulse_play();
    for (int i = 0; i < 4; i++) begin
      wait_valid("s6_wait", n);
      check("s6_sample", 32'(sample_out), 32'(expv(i)));
    end
    check("s6_last", 32'(sample_out), 32'h11);
    repeat (3) step();
    check("s6_idle", 32'(playing), 32'h0);
    vol = 3'd0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/music_player.md
MUSIC_PLAYER -- requirements
Module: music_player

Interface
REQ-001 Parameter MEM_DEPTH, default 80550: number of words in the sample ROM; the last address is MEM_DEPTH-1.
REQ-002 Parameter DIV, default 1134: Clk cycles per sample period (about 44.1 kHz at 50 MHz); legal values are DIV >= 4.
REQ-003 Clk  in  1: single clock; all logic is on the rising edge.
REQ-004 Reset_n  in  1: reset, synchronous, active-low.
REQ-005 play_req  in  1: one-cycle start pulse.
REQ-006 stop_req  in  1: one-cycle abort pulse.
REQ-007 loop_en  in  1: at end of memory, wrap to address 0 instead of stopping.
REQ-008 Add  out  17: ROM address; the ROM returns the addressed word one cycle later.
REQ-009 music_content  in  17: registered ROM read data.
REQ-010 sample_out  out  17: current sample to the codec interface.
REQ-011 sample_valid  out  1: sample_out holds an unconsumed sample.
REQ-012 sample_ack  in  1: codec consumed sample_out; only meaningful while sample_valid=1.
REQ-013 playing  out  1: high in any state other than IDLE.
REQ-014 done  out  1: one-cycle pulse on natural end of playback (non-loop).

Function
REQ-015 The FSM states SHALL be IDLE, READ, LATCH and HOLD.
REQ-016 IDLE with play_req=1: Add<=0, pace counter<=DIV-1, next state READ.
REQ-017 READ always goes to LATCH; this cycle covers the ROM read latency, and Add SHALL be stable throughout READ and LATCH.
REQ-018 LATCH: sample_out<=music_content, sample_valid<=1, next state HOLD.
REQ-019 Pace counter: decrements by 1 every cycle outside IDLE while nonzero, then saturates at 0.
REQ-020 Valid/ack: sample_valid clears on the edge after sample_ack=1; sample_ack while sample_valid=0 is ignored.
REQ-021 HOLD exits when the sample is acked (sample_ack=1 this cycle, or sample_valid already 0) and pace counter=0; sample_valid is 0 after the exit edge.
REQ-022 HOLD exit with Add<MEM_DEPTH-1: Add<=Add+1, pace<=DIV-1, next state READ.
REQ-023 HOLD exit with Add=MEM_DEPTH-1 and loop_en=1: Add<=0, pace<=DIV-1, next state READ, no done pulse.
REQ-024 HOLD exit with Add=MEM_DEPTH-1 and loop_en=0: done=1 for exactly one cycle, Add<=0, next state IDLE.
REQ-025 Sample rate: with sample_ack tied high, consecutive sample_valid rising edges SHALL be exactly DIV cycles apart.
REQ-026 Slow codec: if ack arrives after pace reaches 0, the next READ starts on the edge after ack; no sample is skipped or duplicated.
REQ-027 Addresses: Add never exceeds MEM_DEPTH-1; all arithmetic is 17-bit unsigned.
REQ-028 stop_req in any non-IDLE state: next state IDLE, sample_valid<=0, Add<=0, no done pulse.
REQ-029 play_req outside IDLE is ignored; stop_req in IDLE is a no-op.
REQ-030 play_req and stop_req in the same cycle: stop wins; in IDLE, no start occurs.
REQ-031 loop_en is sampled only at the HOLD exit on the last address.

Reset
REQ-032 With Reset_n=0 at a rising edge: state=IDLE, Add=0, sample_out=0, sample_valid=0, done=0, pace=0.
REQ-033 Reset SHALL take priority over all other inputs, including mid-playback, and no done pulse is generated by reset.
REQ-034 playing SHALL be 0 in the cycle following reset.

Configuration
REQ-035 Macro MUSIC_VOLUME_EN defined: adds input vol (3 bits) and loads sample_out<=music_content>>vol (logical shift) in LATCH; vol=0 gives unity.
REQ-036 Macro MUSIC_VOLUME_EN undefined: the vol port does not exist and sample_out<=music_content unmodified.

Verification
REQ-037 Bench uses MEM_DEPTH=4 and DIV=4, ROM preloaded with {0x00011,0x00022,0x00033,0x00044}.
REQ-038 Scenario 1: play_req, ack tied high, loop_en=0 -> samples 0x11, 0x22, 0x33, 0x44 with valid edges 4 cycles apart, then a single done pulse, then IDLE with Add=0.
REQ-039 Scenario 2: as scenario 1 with loop_en=1 -> the sample after 0x44 is 0x11, there is no done pulse, and playing stays high.
REQ-040 Scenario 3: ack delayed 10 cycles per sample -> each sample is held stable while valid, the next READ follows the ack by 1 cycle, and the sequence is unchanged.
REQ-041 Scenario 4: stop_req during HOLD of 0x22 -> next cycle IDLE, valid=0, Add=0, done=0; play_req and stop_req in the same cycle in IDLE -> stays IDLE.
REQ-042 Scenario 5: Reset_n=0 for one cycle during LATCH -> all outputs at reset values on the following cycle.
REQ-043 Scenario 6: with MUSIC_VOLUME_EN defined and vol=2 -> samples 0x04, 0x08, 0x0C, 0x11.
